// File: rtl/gmii_pkg.sv
// Shared types and defaults for the GMII transmit arbiter.
package gmii_pkg;

    localparam int unsigned GMII_DW     = 8;
    localparam int unsigned LEN_W       = 14;
    localparam int unsigned GAP_W       = 8;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned IFG_DEF     = 12;
    localparam int unsigned MAX_LEN_DEF = 1536;

    localparam logic [LEN_W-1:0] LEN_SAT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } gmii_state_e;

    // FWFT head of one packet buffer
    typedef struct packed {
        logic               valid;
        logic [GMII_DW-1:0] data;
        logic               er;
        logic               last;
    } src_head_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; prio flips away from the winner on each take.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt
);

    logic prio;

    // A lone requester wins outright; a tie goes to prio.
    always_comb begin
        gnt = prio;
        if (req == 2'b01) begin
            gnt = 1'b0;
        end else if (req == 2'b10) begin
            gnt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (take) begin
            prio <= ~gnt;
        end
    end

endmodule

// File: rtl/gmii_tx_arb.sv
// Frame-granular 2:1 arbiter onto one GMII transmit port with IFG and jabber guard.
// Optional per-source frame and error counters when GMII_TX_ARB_STATS_EN is defined.
module gmii_tx_arb
    import gmii_pkg::*;
#(
    parameter int unsigned IFG     = IFG_DEF,
    parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
    input  logic               tx_clk,
    input  logic               rst_n,
    input  logic               s0_valid,
    input  logic [GMII_DW-1:0] s0_data,
    input  logic               s0_er,
    input  logic               s0_last,
    input  logic               s1_valid,
    input  logic [GMII_DW-1:0] s1_data,
    input  logic               s1_er,
    input  logic               s1_last,
    output logic               s0_rd,
    output logic               s1_rd,
    output logic [GMII_DW-1:0] tx_data,
    output logic               tx_en,
    output logic               tx_er,
    output logic               busy
`ifdef GMII_TX_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]   frm_cnt0,
    output logic [CNT_W-1:0]   frm_cnt1,
    output logic [CNT_W-1:0]   err_cnt
`endif
);

    gmii_state_e        state, state_nxt;
    logic               sel, sel_nxt;
    logic [LEN_W-1:0]   len, len_nxt;
    logic [GAP_W-1:0]   gap, gap_nxt;
    logic [GMII_DW-1:0] tx_data_nxt;
    logic               tx_en_nxt, tx_er_nxt;
    logic               take, gnt, pop, jab;
    src_head_t          s0_head, s1_head, head;

    assign s0_head = '{valid: s0_valid, data: s0_data, er: s0_er, last: s0_last};
    assign s1_head = '{valid: s1_valid, data: s1_data, er: s1_er, last: s1_last};
    assign head    = sel ? s1_head : s0_head;

    rr_arb2 u_rr (
        .clk   (tx_clk),
        .rst_n (rst_n),
        .req   ({s1_valid, s0_valid}),
        .take  (take),
        .gnt   (gnt)
    );

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel;
        len_nxt     = len;
        gap_nxt     = gap;
        tx_data_nxt = '0;
        tx_en_nxt   = 1'b0;
        tx_er_nxt   = 1'b0;
        take        = 1'b0;
        pop         = 1'b0;
        jab         = 1'b0;
        unique case (state)
            IDLE: begin
                if (s0_valid || s1_valid) begin
                    take      = 1'b1;
                    sel_nxt   = gnt;
                    len_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                pop         = head.valid;
                jab         = (len >= LEN_W'(MAX_LEN));
                tx_en_nxt   = 1'b1;
                tx_data_nxt = head.valid ? head.data : '0;
                // An empty head cannot stall the PHY, so send an errored idle byte
                tx_er_nxt   = (head.valid ? head.er : 1'b1) | jab;
                if (pop) begin
                    if (len != LEN_SAT) begin
                        len_nxt = len + LEN_W'(1);
                    end
                    if (head.last) begin
                        state_nxt = GAP;
                        gap_nxt   = GAP_W'(IFG - 2);
                    end
                end
            end
            GAP: begin
                if (gap == '0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap - GAP_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel     <= 1'b0;
            len     <= '0;
            gap     <= '0;
            tx_data <= '0;
            tx_en   <= 1'b0;
            tx_er   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            sel     <= sel_nxt;
            len     <= len_nxt;
            gap     <= gap_nxt;
            tx_data <= tx_data_nxt;
            tx_en   <= tx_en_nxt;
            tx_er   <= tx_er_nxt;
            busy    <= (state_nxt != IDLE);
        end
    end

    // Pops are qualified by rst_n so nothing leaves a buffer during reset
    assign s0_rd = rst_n && pop && !sel;
    assign s1_rd = rst_n && pop && sel;

`ifdef GMII_TX_ARB_STATS_EN
    logic frm_done, err_evt;

    assign frm_done = pop && head.last;
    assign err_evt  = (state == SEND) && (!head.valid || jab);

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_cnt0 <= '0;
            frm_cnt1 <= '0;
            err_cnt  <= '0;
        end else begin
            frm_cnt0 <= frm_cnt0 + CNT_W'(frm_done && !sel);
            frm_cnt1 <= frm_cnt1 + CNT_W'(frm_done && sel);
            err_cnt  <= err_cnt + CNT_W'(err_evt);
        end
    end
`endif

endmodule

// File: tb/tb_gmii_tx_arb.sv
// Scoreboard bench for gmii_tx_arb: source models feed an expected GMII symbol queue.
`timescale 1ns/1ps
module tb_gmii_tx_arb;

    localparam int unsigned T_IFG = 12;
    localparam int unsigned T_MAX = 64;

    logic       tx_clk = 1'b0;
    logic       rst_n;
    logic       s0_valid, s1_valid;
    logic [7:0] s0_data, s1_data;
    logic       s0_er, s1_er, s0_last, s1_last;
    logic       s0_rd, s1_rd;
    logic [7:0] tx_data;
    logic       tx_en, tx_er, busy;
`ifdef GMII_TX_ARB_STATS_EN
    logic [15:0] frm_cnt0, frm_cnt1, err_cnt;
`endif

    gmii_tx_arb #(.IFG(T_IFG), .MAX_LEN(T_MAX)) dut (
        .tx_clk   (tx_clk),
        .rst_n    (rst_n),
        .s0_valid (s0_valid),
        .s0_data  (s0_data),
        .s0_er    (s0_er),
        .s0_last  (s0_last),
        .s1_valid (s1_valid),
        .s1_data  (s1_data),
        .s1_er    (s1_er),
        .s1_last  (s1_last),
        .s0_rd    (s0_rd),
        .s1_rd    (s1_rd),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .tx_er    (tx_er),
        .busy     (busy)
`ifdef GMII_TX_ARB_STATS_EN
        ,
        .frm_cnt0 (frm_cnt0),
        .frm_cnt1 (frm_cnt1),
        .err_cnt  (err_cnt)
`endif
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct packed {
        logic [7:0] data;
        logic       er;
        logic       last;
    } sym_t;

    sym_t src_q[2][$];
    sym_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    bit started[2];
    int idx[2];
    int stall_at[2];
    int stall_n[2];
    int frames_done[2];
    bit cv[2];
    bit pv[2];
    bit mprio;
    bit rnd_stall;
    bit flush_req;

    bit mon_en;
    bit exact_gap;
    bit in_run;
    bit seen_frame;
    int run_len, run_er, low_run, last_run, last_er, runs;
    sym_t last_sym;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic make_frame(input int s, input int len, input bit rnd);
        sym_t b;
        for (int i = 0; i < len; i++) begin
            b.data = rnd ? 8'($urandom) : 8'(i);
            b.er   = rnd ? ($urandom_range(0, 15) == 0) : 1'b0;
            b.last = (i == len - 1);
            src_q[s].push_back(b);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        do begin
            @(negedge tx_clk); #1;
            n++;
        end while (!(src_q[0].size() == 0 && src_q[1].size() == 0 && !busy && !tx_en) && n < budget);
        check({name, "_timeout"}, longint'(n >= budget), 0);
    endtask

    // Source models: present FWFT heads, honour pops, build expected symbols
    initial begin
        bit   stall;
        bit   p[2];
        sym_t b, e;
        int   exp_src;
        s0_valid = 0; s0_data = 0; s0_er = 0; s0_last = 0;
        s1_valid = 0; s1_data = 0; s1_er = 0; s1_last = 0;
        for (int s = 0; s < 2; s++) begin
            started[s] = 0; idx[s] = 0; stall_at[s] = -1; stall_n[s] = 0;
            frames_done[s] = 0; cv[s] = 0; pv[s] = 0;
        end
        mprio = 0;
        forever begin
            @(negedge tx_clk);
            if (flush_req) begin
                for (int s = 0; s < 2; s++) begin
                    src_q[s].delete();
                    started[s] = 0; idx[s] = 0; stall_at[s] = -1; stall_n[s] = 0; pv[s] = 0;
                end
                exp_q.delete();
                mprio = 0;
                flush_req = 0;
            end
            for (int s = 0; s < 2; s++) begin
                stall = 0;
                if (started[s] && src_q[s].size() > 0) begin
                    if (stall_n[s] > 0 && idx[s] == stall_at[s]) begin
                        stall = 1;
                        stall_n[s]--;
                    end else if (rnd_stall && $urandom_range(0, 7) == 0) begin
                        stall = 1;
                    end
                end
                cv[s] = (src_q[s].size() > 0) && !stall;
            end
            s0_valid = cv[0];
            s1_valid = cv[1];
            if (cv[0]) begin
                s0_data = src_q[0][0].data; s0_er = src_q[0][0].er; s0_last = src_q[0][0].last;
            end else begin
                s0_data = 8'($urandom); s0_er = 1'($urandom); s0_last = 1'($urandom);
            end
            if (cv[1]) begin
                s1_data = src_q[1][0].data; s1_er = src_q[1][0].er; s1_last = src_q[1][0].last;
            end else begin
                s1_data = 8'($urandom); s1_er = 1'($urandom); s1_last = 1'($urandom);
            end
            #4;
            p[0] = s0_rd;
            p[1] = s1_rd;
            @(posedge tx_clk);
            if (p[0] && p[1]) check("rd_both", 1, 0);
            for (int s = 0; s < 2; s++) begin
                if (p[s] && !cv[s]) check("rd_without_valid", s, -1);
                if (started[s] && !cv[s]) begin
                    e.data = 8'h00; e.er = 1'b1; e.last = 1'b0;
                    exp_q.push_back(e);
                end else if (p[s] && cv[s]) begin
                    b = src_q[s].pop_front();
                    if (!started[s]) begin
                        exp_src = (pv[0] && pv[1]) ? int'(mprio) : (pv[1] ? 1 : 0);
                        check("grant_src", s, exp_src);
                        mprio = (exp_src == 0);
                        started[s] = 1;
                        idx[s] = 0;
                    end
                    e.data = b.data;
                    e.er   = b.er | (idx[s] >= int'(T_MAX));
                    e.last = b.last;
                    exp_q.push_back(e);
                    idx[s]++;
                    if (b.last) begin
                        started[s] = 0;
                        frames_done[s]++;
                    end
                end
            end
            pv[0] = cv[0];
            pv[1] = cv[1];
        end
    end

    // Monitor: compare every transmitted symbol and every inter-frame gap
    initial begin
        sym_t e;
        forever begin
            @(negedge tx_clk); #1;
            if (!mon_en) begin
                in_run = 0; seen_frame = 0; low_run = 0;
                continue;
            end
            if (tx_en) begin
                if (!in_run) begin
                    if (seen_frame) begin
                        if (exact_gap) check("ifg_exact", low_run, T_IFG);
                        else           check("ifg_min", longint'(low_run >= int'(T_IFG)), 1);
                    end
                    in_run = 1; run_len = 0; run_er = 0;
                end
                run_len++;
                if (tx_er) run_er++;
                if (exp_q.size() == 0) begin
                    check("unexpected_tx", tx_data, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", tx_data, e.data);
                    check("tx_er", tx_er, e.er);
                    last_sym = e;
                end
            end else begin
                if (in_run) begin
                    check("frame_end_on_last", last_sym.last, 1);
                    in_run = 0; seen_frame = 1;
                    last_run = run_len; last_er = run_er; runs++;
                    low_run = 0;
                end
                low_run++;
                check("tx_er_idle", tx_er, 0);
            end
        end
    end

    initial begin
        int k;
        int runs0;
`ifdef GMII_TX_ARB_STATS_EN
        int err0;
`endif
        rst_n = 0; mon_en = 0; exact_gap = 0; rnd_stall = 0; flush_req = 0; runs = 0;
        repeat (3) @(negedge tx_clk);
        #1;
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_er", tx_er, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_rd", {s1_rd, s0_rd}, 0);
        @(negedge tx_clk);
        rst_n = 1;
        mon_en = 1;

        // Contention: both sources hold 60-byte frames
        exact_gap = 1;
        runs0 = runs;
        for (int f = 0; f < 4; f++) begin
            make_frame(0, 60, 0);
            make_frame(1, 60, 0);
        end
        wait_idle(3000, "contention");
        check("contention_frames", runs - runs0, 8);
        check("contention_len", last_run, 60);
        exact_gap = 0;

        // Single 64-byte frame: grant latency, length, no error
        make_frame(0, 64, 0);
        k = 0;
        while (!s0_valid && k < 10) begin @(negedge tx_clk); #1; k++; end
        check("s0_valid_seen", longint'(s0_valid), 1);
        k = 0;
        while (!tx_en && k < 10) begin @(negedge tx_clk); #1; k++; end
        check("grant_latency", k, 2);
        wait_idle(500, "single");
        check("single_len", last_run, 64);
        check("single_er", last_er, 0);

        // Underrun: s1 drops valid for 3 cycles at byte 10 of 20
        stall_at[1] = 10;
        stall_n[1]  = 3;
        make_frame(1, 20, 0);
        wait_idle(500, "underrun");
        check("underrun_len", last_run, 23);
        check("underrun_er", last_er, 3);
        stall_at[1] = -1;

        // Jabber: 70-byte frame against MAX_LEN 64
`ifdef GMII_TX_ARB_STATS_EN
        err0 = int'(err_cnt);
`endif
        make_frame(0, 70, 0);
        wait_idle(500, "jabber");
        check("jabber_len", last_run, 70);
        check("jabber_er", last_er, 6);
`ifdef GMII_TX_ARB_STATS_EN
        check("jabber_err_cnt", int'(err_cnt) - err0, 6);
`endif

        // Random traffic with random underruns
        rnd_stall = 1;
        for (int f = 0; f < 40; f++) begin
            make_frame(int'($urandom_range(0, 1)), int'($urandom_range(1, 80)), 1);
            repeat ($urandom_range(0, 30)) @(negedge tx_clk);
            #1;
        end
        wait_idle(20000, "random");
        rnd_stall = 0;
        check("exp_q_drained", exp_q.size(), 0);
`ifdef GMII_TX_ARB_STATS_EN
        check("frm_cnt0", frm_cnt0, 16'(frames_done[0]));
        check("frm_cnt1", frm_cnt1, 16'(frames_done[1]));
`endif

        // Reset mid-frame at byte 30
        make_frame(1, 60, 0);
        make_frame(0, 60, 0);
        k = 0;
        do begin @(negedge tx_clk); #2; k++; end while (!(in_run && run_len >= 30) && k < 500);
        check("reset_reach_byte30", longint'(k >= 500), 0);
        rst_n = 0;
        #1;
        check("mid_rst_tx_en", tx_en, 0);
        check("mid_rst_tx_er", tx_er, 0);
        check("mid_rst_rd", {s1_rd, s0_rd}, 0);
        check("mid_rst_busy", busy, 0);
        mon_en = 0;
        flush_req = 1;
        k = 0;
        while (flush_req && k < 10) begin @(negedge tx_clk); #1; k++; end
        check("flush_done", flush_req, 0);
        repeat (2) @(negedge tx_clk);
        rst_n = 1;
        #1;
        mon_en = 1;
        make_frame(0, 10, 0);
        make_frame(1, 10, 0);
        k = 0;
        do begin @(negedge tx_clk); #4; k++; end while (!(s0_rd || s1_rd) && k < 20);
        check("post_rst_first_s0", {s1_rd, s0_rd}, 2'b01);
        wait_idle(500, "post_reset");
        check("post_rst_len", last_run, 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gmii_tx_arb.md
# gmii_tx_arb

Two-source, frame-granular round-robin arbiter that shares one GMII transmit port between two FWFT packet buffers (e.g. two rx-to-tx packet FIFOs). It runs entirely in the tx clock domain, pops whole frames from the granted source and enforces a minimum inter-frame gap. It flags underrun and over-length frames on `tx_er`. It sits between the packet buffers' read side and the PHY/MAC transmit pins.

## Interface
- `IFG`, 12, minimum idle cycles on `tx_en` between frames. Legal range 2..255.
- `MAX_LEN`, 1536, byte count after which the rest of the frame is forced errored (jabber guard). Legal range 64..16383.
- `tx_clk`  in  1  transmit clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s0_valid`, `s1_valid`  in  1 each  source has a word at its FWFT head.
- `s0_data`, `s1_data`  in  8 each  head byte.
- `s0_er`, `s1_er`  in  1 each  head error flag.
- `s0_last`, `s1_last`  in  1 each  head byte is the final byte of its frame.
- `s0_rd`, `s1_rd`  out  1 each  pop strobe. Combinational from state and `valid`.
- `tx_data`  out  8  GMII transmit data, registered.
- `tx_en`  out  1  GMII transmit enable, registered.
- `tx_er`  out  1  GMII transmit error, registered.
- `busy`  out  1  state is not IDLE.

## Operation
- The FSM has three states: IDLE, SEND and GAP. It holds registers `sel` (granted source), `prio` (next preferred source), `len[13:0]` and `gap[7:0]`.
- **IDLE:**
  - If exactly one `sN_valid` is high, set `sel=N`.
  - If both are high, set `sel=prio`.
  - On a grant, set `prio=~sel` and `len=0`, then go to SEND. With no valid source, stay in IDLE.
- **SEND:**
  - `s<sel>_rd = s<sel>_valid`. The other `rd` is 0.
  - Each cycle in SEND, the output registers load:
    - `tx_en=1`
    - `tx_data = valid ? head data : 8'h00`
    - `tx_er = (valid ? head er : 1) | (len >= MAX_LEN)`
  - `len` increments on every pop and saturates at 16383.
- **Underrun** (`valid` low in SEND): GMII cannot stall, so the arbiter emits the errored idle byte described above, stays in SEND and keeps waiting for the remainder of the frame.
- **Frame end:** a pop with `last=1` moves the FSM to GAP with `gap=IFG-2`.
- **GAP:** decrement `gap`, ignore all requests, and go to IDLE when `gap==0`.
- **Reset:**
  - All outputs reset to 0, and `prio` resets to 0.
  - The state resets to IDLE.
  - A reset asserted mid-frame truncates `tx_en` immediately. No pop occurs while `rst_n` is low.
- `sN_last`, `sN_data` and `sN_er` are ignored unless `sN_rd` is high.

## Timing
- Grant latency: with `sN_valid` high in an IDLE cycle t, the first pop occurs in cycle t+1 and the first byte appears on `tx_en`/`tx_data` after the edge at the end of t+1 (visible in cycle t+2).
- A frame of L bytes with no underrun holds `tx_en` high for exactly L consecutive cycles.
- Gap timing:
  - Last pop at cycle T gives GAP for cycles T+1..T+IFG-1 and IDLE at T+IFG.
  - The earliest next pop is T+IFG+1.
  - This yields exactly `IFG` low cycles of `tx_en` between back-to-back frames.
- When a frame ends while both sources are pending, grants alternate strictly: 0,1,0,1…

## Configuration
- `GMII_TX_ARB_STATS_EN`, when defined, adds three outputs:
  - `frm_cnt0[15:0]` and `frm_cnt1[15:0]`: completed frames per source.
  - `err_cnt[15:0]`: underrun cycles plus jabber-flagged bytes.
- All three counters wrap, are cleared by reset, and increment one cycle after the event.
- When the macro is undefined, these ports and counters do not exist and the datapath timing is identical.

## Structure
- Shared package `gmii_pkg`: state encoding (IDLE=2'd0, SEND=2'd1, GAP=2'd2), `GMII_DW=8`, and the `IFG`/`MAX_LEN` defaults.
- One sub-module, `rr_arb2`: a 2-way round-robin grant with its `prio` register, taking inputs `req[1:0]` and `take`, and producing output `gnt`. All other logic stays in the top level.

## Test plan
- Single frame, back-to-back sources:
  - Stimulus: s0 presents 64 bytes 0x00..0x3F with `last` on 0x3F; s1 idle.
  - Response: `tx_en` high 64 cycles starting 2 cycles after `s0_valid`, data in order, `tx_er=0`, then at least 12 low cycles.
- Contention:
  - Stimulus: both sources continuously hold 60-byte frames.
  - Response: `tx` sequence s0,s1,s0,s1 with exactly `IFG`=12 idle cycles between frames.
- Underrun:
  - Stimulus: s1 drops `valid` for 3 cycles at byte 10 of 20.
  - Response: 3 cycles of `tx_en=1, tx_er=1, tx_data=0x00`, then bytes 10..19, for a total `tx_en` run of 23 cycles.
- Jabber:
  - Stimulus: `MAX_LEN`=64, 70-byte frame.
  - Response: bytes 1..64 have `tx_er=0` and bytes 65..70 have `tx_er=1`; with `GMII_TX_ARB_STATS_EN` defined, `err_cnt=6`.
- Reset mid-frame:
  - Stimulus: `rst_n` low at byte 30.
  - Response: `tx_en`, `tx_er`, `s0_rd`, `s1_rd` and `busy` go to 0 asynchronously; after release, s0 is granted first (`prio=0`).
